// File: rtl/i2c_pkg.sv
// i2c_pkg: state encoding, SCL phase selects and bus constants shared by the I2C byte primitives
package i2c_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOW, S_RISE, S_HIGH, S_DONE, S_ABORT} state_t;
    localparam int DEF_DIV = 4;
    localparam int DEF_STRETCH_MAX = 1024;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    localparam logic [1:0] PH_OFF = 2'd0;
    localparam logic [1:0] PH_LOW = 2'd1;
    localparam logic [1:0] PH_HIGH = 2'd2;
endpackage

// File: rtl/i2c_scl_timer.sv
// i2c_scl_timer: SCL half-period timing with slave stretch wait and stretch timeout
module i2c_scl_timer
    import i2c_pkg::*;
#(
    parameter int DIV = DEF_DIV,
    parameter int STRETCH_MAX = DEF_STRETCH_MAX
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start,
    input  logic       scl_in,
    input  logic [1:0] phase,
    output logic       phase_done,
    output logic       mid_high,
    output logic       timeout
);
    localparam int QW = $clog2(2 * DIV);
    localparam int SW = $clog2(STRETCH_MAX + 1);
    logic [QW-1:0] r_q;
    logic [SW-1:0] r_s;
    logic w_wait, w_en;
    // the high half only starts counting once the bus is seen high; later drops are ignored
    always_comb begin
        w_wait = phase == PH_HIGH && r_q == '0 && !scl_in;
        w_en = phase == PH_LOW || (phase == PH_HIGH && !w_wait);
        phase_done = w_en && r_q == QW'(2 * DIV - 1);
        mid_high = phase == PH_HIGH && r_q == QW'(DIV);
        timeout = w_wait && r_s == SW'(STRETCH_MAX - 1);
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
            r_s <= '0;
        end else begin
            r_q <= (start || phase_done || !w_en) ? '0 : r_q + 1'b1;
            r_s <= !w_wait ? '0 : (r_s == SW'(STRETCH_MAX)) ? r_s : r_s + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_master_read_byte.sv
// i2c_master_read_byte: clocks in a DATA_WIDTH-bit word MSB first, then drives ACK/NACK
module i2c_master_read_byte
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV = DEF_DIV,
    parameter int STRETCH_MAX = DEF_STRETCH_MAX
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  go,
    input  logic                  ack_en,
    output logic                  busy,
    output logic                  finish,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic                  scl_in,
    output logic                  scl
);
    localparam int BW = $clog2(DATA_WIDTH + 2);
    state_t r_state, w_next;
    logic [BW-1:0] r_bit;
    logic [DATA_WIDTH-1:0] r_sr;
    logic r_ack_bit, r_scl;
    logic w_start, w_last, w_phase_done, w_mid_high, w_timeout;
    logic [1:0] w_phase;

    assign w_start = r_state == S_IDLE && go;
    assign w_last = r_bit == BW'(DATA_WIDTH);
    assign w_phase = r_state == S_LOW ? PH_LOW : (r_state == S_RISE || r_state == S_HIGH) ? PH_HIGH : PH_OFF;

    i2c_scl_timer #(.DIV(DIV), .STRETCH_MAX(STRETCH_MAX)) u_timer (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (w_start),
        .scl_in     (scl_in),
        .phase      (w_phase),
        .phase_done (w_phase_done),
        .mid_high   (w_mid_high),
        .timeout    (w_timeout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: w_next = go ? S_LOW : S_IDLE;
            S_LOW: w_next = w_phase_done ? S_RISE : S_LOW;
            S_RISE: w_next = w_timeout ? S_ABORT : scl_in ? S_HIGH : S_RISE;
            S_HIGH: w_next = !w_phase_done ? S_HIGH : w_last ? S_DONE : S_LOW;
            default: w_next = S_IDLE;
        endcase
    end

    // idle keeps the last driven SCL level so the bus stays owned between primitives
    always_comb begin
        busy = r_state inside {S_LOW, S_RISE, S_HIGH};
        finish = r_state == S_DONE;
        err = r_state == S_ABORT;
        sda_oe = (r_state inside {S_LOW, S_RISE, S_HIGH}) && w_last && r_ack_bit == ACK;
        scl = r_state == S_IDLE ? r_scl : !(r_state == S_LOW || r_state == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bit <= '0;
            r_sr <= '0;
            r_ack_bit <= NACK;
            r_scl <= 1'b1;
            data <= '0;
        end else begin
            r_scl <= scl;
            if (w_start) begin
                r_bit <= '0;
                r_ack_bit <= ack_en ? ACK : NACK;
            end else if (r_state == S_HIGH && w_phase_done && !w_last) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_mid_high && !w_last) r_sr <= DATA_WIDTH'({r_sr, sda_in});
            if (w_next == S_DONE) data <= r_sr;
        end
    end
endmodule

// File: tb/tb_i2c_master_read_byte.sv
// tb_i2c_master_read_byte: directed scenarios against a simple slave model on three parameterisations
module tb_i2c_master_read_byte;
    logic clock = 0, reset_n = 0;
    int checks = 0, errors = 0, cyc = 0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    logic go, ack_en, busy, finish, err, sda_in, sda_oe, scl_in, scl;
    logic [7:0] data;
    logic [15:0] word = '0;
    int c = 0, rises = 0, oe_cnt = 0, oe_last = 0, err_cnt = 0, sc = 0, s_len = 0;
    logic p_scl = 1'b1, p_busy = 1'b0;
    assign scl_in = scl && !(s_len != 0 && c == 3 && sc < s_len);
    assign sda_in = !sda_oe && (c < 8 ? word[4'(7 - c)] : 1'b1);

    i2c_master_read_byte #(.DATA_WIDTH(8), .DIV(4), .STRETCH_MAX(1024)) u_dut (
        .clock(clock), .reset_n(reset_n), .go(go), .ack_en(ack_en), .busy(busy), .finish(finish),
        .err(err), .data(data), .sda_in(sda_in), .sda_oe(sda_oe), .scl_in(scl_in), .scl(scl)
    );

    always @(negedge clock) begin
        p_scl <= scl_in;
        p_busy <= busy;
        c <= !busy ? 0 : (p_busy && p_scl && !scl_in) ? c + 1 : c;
        if (busy && scl_in && !p_scl) rises <= rises + 1;
        if (sda_oe) begin
            oe_cnt <= oe_cnt + 1;
            oe_last <= cyc;
        end
        if (err) err_cnt <= err_cnt + 1;
    end
    always @(posedge clock) sc <= !busy ? 0 : (scl && !scl_in) ? sc + 1 : sc;

    logic go2 = 0, stuck = 0, bz2, f2, e2, oe2, scl2;
    logic [7:0] d2;
    i2c_master_read_byte #(.DATA_WIDTH(8), .DIV(4), .STRETCH_MAX(16)) u_sm (
        .clock(clock), .reset_n(reset_n), .go(go2), .ack_en(1'b0), .busy(bz2), .finish(f2),
        .err(e2), .data(d2), .sda_in(!oe2), .sda_oe(oe2), .scl_in(scl2 && !stuck), .scl(scl2)
    );

    logic go3 = 0, bz3, f3, e3, oe3, scl3, sda_in3, p3 = 1'b1, pb3 = 1'b0;
    logic [11:0] d3;
    logic [15:0] word3 = '0;
    int c3 = 0;
    assign sda_in3 = !oe3 && (c3 < 12 ? word3[4'(11 - c3)] : 1'b1);
    i2c_master_read_byte #(.DATA_WIDTH(12), .DIV(4), .STRETCH_MAX(1024)) u_w12 (
        .clock(clock), .reset_n(reset_n), .go(go3), .ack_en(1'b1), .busy(bz3), .finish(f3),
        .err(e3), .data(d3), .sda_in(sda_in3), .sda_oe(oe3), .scl_in(scl3), .scl(scl3)
    );
    always @(negedge clock) begin
        p3 <= scl3;
        pb3 <= bz3;
        c3 <= !bz3 ? 0 : (pb3 && p3 && !scl3) ? c3 + 1 : c3;
    end

    task automatic test_reset;
        repeat (2) @(negedge clock);
        checks++; if (scl !== 1'b1) begin errors++; $display("FAIL reset_scl: got %b want 1", scl); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if ({finish, err} !== 2'b00) begin errors++; $display("FAIL reset_pulses: got %b want 00", {finish, err}); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        reset_n = 1;
    endtask

    task automatic test_read(input string nm, input logic [7:0] w, input logic a, input int sl, input int lat, input int oe_n);
        int t0, r0, o0, e0, tf;
        word = {8'h00, w};
        ack_en = a;
        s_len = sl;
        @(negedge clock);
        go = 1;
        t0 = cyc; r0 = rises; o0 = oe_cnt; e0 = err_cnt;
        @(negedge clock);
        go = 0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_after_go: got %b want 1", nm, busy); end
        tf = 0;
        for (int i = 0; i < 500 && tf == 0; i++) begin
            if (finish === 1'b1) tf = cyc;
            else @(negedge clock);
        end
        checks++; if (tf == 0) begin errors++; $display("FAIL %s finish_timeout: got none want finish within 500", nm); end
        checks++; if (tf - t0 + 1 !== lat) begin errors++; $display("FAIL %s latency: got %0d want %0d", nm, tf - t0 + 1, lat); end
        checks++; if (data !== w) begin errors++; $display("FAIL %s data: got %h want %h", nm, data, w); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_at_finish: got %b want 0", nm, busy); end
        checks++; if (rises - r0 !== 9) begin errors++; $display("FAIL %s scl_pulses: got %0d want 9", nm, rises - r0); end
        checks++; if (oe_cnt - o0 !== oe_n) begin errors++; $display("FAIL %s sda_oe_cycles: got %0d want %0d", nm, oe_cnt - o0, oe_n); end
        if (oe_n > 0) begin
            checks++; if (oe_last !== tf - 1) begin errors++; $display("FAIL %s sda_oe_last: got %0d want %0d", nm, oe_last, tf - 1); end
        end
        checks++; if (err_cnt !== e0) begin errors++; $display("FAIL %s err_seen: got %0d want 0", nm, err_cnt - e0); end
        @(negedge clock);
        checks++; if (finish !== 1'b0) begin errors++; $display("FAIL %s finish_width: got %b want 0", nm, finish); end
        checks++; if (scl !== 1'b0) begin errors++; $display("FAIL %s idle_scl: got %b want 0", nm, scl); end
        s_len = 0;
    endtask

    task automatic test_stretch_timeout;
        int t0, te, tf;
        @(negedge clock);
        go2 = 1;
        @(negedge clock);
        go2 = 0;
        tf = 0;
        for (int i = 0; i < 300 && tf == 0; i++) begin
            if (f2 === 1'b1) tf = cyc;
            else @(negedge clock);
        end
        checks++; if (tf == 0 || d2 !== 8'hFF) begin errors++; $display("FAIL to_prior_data: got %h want ff", d2); end
        stuck = 1;
        @(negedge clock);
        go2 = 1;
        t0 = cyc;
        @(negedge clock);
        go2 = 0;
        te = 0; tf = 0;
        for (int i = 0; i < 100 && te == 0; i++) begin
            if (f2 === 1'b1) tf = cyc;
            if (e2 === 1'b1) te = cyc;
            else @(negedge clock);
        end
        checks++; if (te == 0) begin errors++; $display("FAIL to_err: got none want err within 100"); end
        checks++; if (tf != 0) begin errors++; $display("FAIL to_finish: got finish at %0d want none", tf); end
        checks++; if (te - t0 !== 25) begin errors++; $display("FAIL to_latency: got %0d want 25", te - t0); end
        checks++; if ({scl2, bz2} !== 2'b10) begin errors++; $display("FAIL to_abort_bus: got scl/busy %b want 10", {scl2, bz2}); end
        checks++; if (d2 !== 8'hFF) begin errors++; $display("FAIL to_data_kept: got %h want ff", d2); end
        @(negedge clock);
        checks++; if ({e2, scl2, bz2} !== 3'b010) begin errors++; $display("FAIL to_after: got err/scl/busy %b want 010", {e2, scl2, bz2}); end
        stuck = 0;
    endtask

    task automatic test_reset_mid_transfer;
        int seen;
        word = 16'h00C3;
        ack_en = 1;
        @(negedge clock);
        go = 1;
        @(negedge clock);
        go = 0;
        seen = 0;
        for (int i = 0; i < 300 && seen == 0; i++) begin
            if (c == 5) seen = 1;
            else @(negedge clock);
        end
        checks++; if (seen == 0) begin errors++; $display("FAIL rst_mid_reach: got no bit 5 want bit 5"); end
        repeat (6) @(negedge clock);
        #2 reset_n = 0;
        #1;
        checks++; if ({busy, scl, sda_oe, finish, err} !== 5'b01000) begin errors++; $display("FAIL rst_mid_outputs: got %b want 01000", {busy, scl, sda_oe, finish, err}); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h want 00", data); end
        @(negedge clock);
        reset_n = 1;
        test_read("post_reset", 8'h96, 1'b1, 0, 146, 16);
    endtask

    task automatic test_back_to_back;
        int f1, fb;
        word = 16'h0001;
        ack_en = 1;
        @(negedge clock);
        go = 1;
        f1 = 0;
        for (int i = 0; i < 400 && f1 == 0; i++) begin
            @(negedge clock);
            if (finish === 1'b1) f1 = cyc;
        end
        checks++; if (f1 == 0 || data !== 8'h01) begin errors++; $display("FAIL b2b_first: got %h want 01", data); end
        word = 16'h0080;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy %b want 0", busy); end
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy %b want 1", busy); end
        fb = 0;
        for (int i = 0; i < 400 && fb == 0; i++) begin
            @(negedge clock);
            if (finish === 1'b1) fb = cyc;
        end
        go = 0;
        checks++; if (data !== 8'h80) begin errors++; $display("FAIL b2b_second: got %h want 80", data); end
        checks++; if (fb - f1 - 1 !== 145) begin errors++; $display("FAIL b2b_gap: got %0d want 145", fb - f1 - 1); end
        @(negedge clock);
    endtask

    task automatic test_width12;
        int t0, tf;
        word3 = 16'h0A5C;
        @(negedge clock);
        go3 = 1;
        t0 = cyc;
        @(negedge clock);
        go3 = 0;
        tf = 0;
        for (int i = 0; i < 500 && tf == 0; i++) begin
            if (f3 === 1'b1) tf = cyc;
            else @(negedge clock);
        end
        checks++; if (tf - t0 + 1 !== 210) begin errors++; $display("FAIL w12_latency: got %0d want 210", tf - t0 + 1); end
        checks++; if (d3 !== 12'hA5C) begin errors++; $display("FAIL w12_data: got %h want a5c", d3); end
    endtask

    initial begin
        go = 0;
        ack_en = 0;
        test_reset;
        test_read("ack_a5", 8'hA5, 1'b1, 0, 146, 16);
        test_read("nack_3c", 8'h3C, 1'b0, 0, 146, 0);
        test_read("stretch_50", 8'h5A, 1'b1, 50, 196, 16);
        test_stretch_timeout;
        test_reset_mid_transfer;
        test_back_to_back;
        test_width12;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/i2c_master_read_byte.md
Name: i2c_master_read_byte

Overview:
Parametrised successor to the single-bit I2C master read primitive. It clocks in a DATA_WIDTH-bit word MSB first on SCL, then drives the ACK/NACK bit. SCL timing is programmable through a divider, slave clock stretching is honoured, and a stretch timeout flags a stuck bus. It sits under the I2C master control FSM, beside the write-byte, start and stop primitives, and shares the open-drain SCL/SDA pads with them.

Parameters:
DATA_WIDTH, 8, bits per transfer (1..16), received MSB first
DIV, 4, system clocks per SCL quarter-period (>=2)
STRETCH_MAX, 1024, max clocks the block waits for SCL to rise before aborting (>=1)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
go  in  1  start request, level, sampled only in IDLE
ack_en  in  1  sampled with go; 1 = drive ACK (SDA low) after data, 0 = NACK (release)
busy  out  1  high from the cycle after go is accepted until finish/err
finish  out  1  one-cycle pulse, transfer complete, data valid
err  out  1  one-cycle pulse, stretch timeout, transfer aborted
data  out  DATA_WIDTH  received word, updated only on finish
sda_in  in  1  synchronised SDA pad value
sda_oe  out  1  1 = pull SDA low, 0 = release
scl_in  in  1  synchronised SCL pad value (stretch detect)
scl  out  1  SCL drive, 1 = release/high, 0 = pull low

Behaviour:
- Reset (async, immediate, any state): state=IDLE, scl=1, sda_oe=0, busy=0, finish=0, err=0, data=0, shift reg=0, counters=0.
- States: IDLE, LOW, RISE, HIGH, DONE, ABORT.
- IDLE: go=1 -> LOW. Latch ack_en. Clear bit counter. busy=1 from next cycle.
- LOW: scl=0 for 2*DIV clocks. sda_oe=0 during data bits; sda_oe=ack_latched during the ACK bit, set on the first LOW clock. -> RISE.
- RISE: scl=1 (released). Wait for scl_in=1 -> HIGH. Stretch counter increments each clock while scl_in=0. Reaching STRETCH_MAX -> ABORT.
- HIGH: scl=1 for 2*DIV clocks, counted from the first cycle scl_in=1. sda_in is sampled on clock index DIV (mid-high) and shifted into the shift reg LSB-side (MSB first overall). ACK-bit sample is discarded.
- End of HIGH: bit counter < DATA_WIDTH (DATA_WIDTH+1 bits total incl. ACK) -> LOW with counter+1. Otherwise -> DONE.
- DONE: one cycle. finish=1, data<=shift reg, scl=0, sda_oe=0, busy=0. -> IDLE.
- ABORT: one cycle. err=1, scl=1, sda_oe=0, busy=0, data unchanged. -> IDLE.
- IDLE outputs: sda_oe=0. scl holds its last value (0 after a transfer, 1 after reset/abort), so the bus is kept owned for the next primitive.
- go while busy: ignored. go still high in the finish cycle: a new transfer starts the next cycle. This back-to-back behaviour is legal and used for multi-byte reads.
- Latency: go to finish = (DATA_WIDTH+1)*4*DIV + total stretch cycles + 2 clocks.
- Widths: bit counter $clog2(DATA_WIDTH+2). Quarter counter $clog2(2*DIV). Stretch counter $clog2(STRETCH_MAX+1). All saturate/clear on state change, with no wrap-around.
- scl_in dropping during HIGH (another master/glitch): ignored, timing continues from the counter.

Decomposition:
- Shared package i2c_pkg: state encoding enum, default DIV/STRETCH_MAX constants, ACK=1'b0/NACK=1'b1 constants. The write-byte primitive reuses these.
- Sub-module i2c_scl_timer: quarter/half-period counter with stretch wait and timeout. Inputs: start, scl_in, phase select. Outputs: phase_done, mid_high, timeout. Shared later with the write-byte block.

Test Plan:
- DATA_WIDTH=8, DIV=4, ack_en=1, slave returns 0xA5, no stretch -> finish after 9*16+2=146 clocks, data=0xA5, sda_oe=1 only during 9th bit, 9 SCL high pulses.
- ack_en=0, slave returns 0x3C -> data=0x3C, sda_oe stays 0 for whole transfer.
- Slave holds scl_in low 50 clocks at bit 3 -> finish delayed by exactly 50 clocks, data correct, no err.
- STRETCH_MAX=16, scl_in stuck low -> err pulses once, finish never, scl=1, busy=0, data keeps previous value.
- reset_n low mid-bit 5, then go -> outputs at reset values immediately; next transfer completes correctly from bit 0.
- go held high across two transfers (0x01 then 0x80) -> two finish pulses separated by 145 clocks, data=0x01 then 0x80; DATA_WIDTH=12 rerun of first case passes.
